axi_master_wr_issuer: RTL and testbench

//  Rx-side AXI master write engine; mirror of the Tx AXI slave path.
//  - Takes one decoded inbound write request (descriptor + payload beats) from the Rx router.
//  - Issues it to the application as one AXI4 INCR burst on AW/W.
//  - Waits for B.
//  - For non-posted writes (IO/Cfg), returns a completion status to the completion generator.
//  - One transaction outstanding at a time.

---
 rtl/axi_master_wr_issuer_pkg.sv | 48 ++++
 rtl/axi_master_wr_issuer_if.sv | 41 ++++
 rtl/axi_master_wr_issuer_wstrb_gen.sv | 42 ++++
 rtl/axi_master_wr_issuer.sv | 177 +++++++++++++++++
 tb/tb_axi_master_wr_issuer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_master_wr_issuer_pkg.sv
// Shared types and constants for the Rx-side AXI master write issuer:
// FSM states, completion status codes, BRESP encodings and the captured
// write descriptor.
package axi_master_wr_issuer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_CPL  = 3'd4
  } wr_state_t;

  typedef logic [2:0] cpl_status_t;

  localparam cpl_status_t CPL_SC = 3'b000;
  localparam cpl_status_t CPL_UR = 3'b001;
  localparam cpl_status_t CPL_CA = 3'b100;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Descriptor fields kept for the lifetime of one transaction; n is the
  // decoded DW count (1..1024), so a length field of 0 never reaches here.
  typedef struct packed {
    logic [10:0] n;
    logic [3:0]  first_be;
    logic [3:0]  last_be;
    logic        np;
    logic [9:0]  tag;
    logic [15:0] requester_id;
  } wr_desc_t;

  // OKAY and EXOKAY both mean success; decode errors become Unsupported
  // Request and slave errors become Completer Abort.
  function automatic cpl_status_t bresp_to_status(input logic [1:0] bresp);
    case (bresp)
      BRESP_SLVERR: bresp_to_status = CPL_CA;
      BRESP_DECERR: bresp_to_status = CPL_UR;
      default:      bresp_to_status = CPL_SC;
    endcase
  endfunction

endpackage

// File: rtl/axi_master_wr_issuer_if.sv
// AXI4 write-address / write-data / write-response channels between the
// issuer (master) and the application (slave).
interface axi_master_wr_issuer_if #(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
);

  logic                        AWVALID;
  logic                        AWREADY;
  logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]                  AWLEN;
  logic [2:0]                  AWSIZE;
  logic [1:0]                  AWBURST;
  logic [AXI_ID_WIDTH-1:0]     AWID;

  logic                        WVALID;
  logic                        WREADY;
  logic [AXI_DATA_WIDTH-1:0]   WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                        WLAST;

  logic                        BVALID;
  logic                        BREADY;
  logic [1:0]                  BRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    output WVALID, WDATA, WSTRB, WLAST,
    output BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
    input  WVALID, WDATA, WSTRB, WLAST,
    input  BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/axi_master_wr_issuer_wstrb_gen.sv
// Byte-strobe generator for one W beat. Each 32-bit lane has a global DW
// index g = beat*LANES + lane; lanes outside [off, off+n) are dark, the
// first and last DW use their byte enables, everything between is full.
module axi_master_wr_issuer_wstrb_gen #(
  parameter int LANES = 8,
  parameter int OFF_W = 3
) (
  input  logic [7:0]         beat,
  input  logic [OFF_W-1:0]   off,
  input  logic [10:0]        n,
  input  logic [3:0]         first_be,
  input  logic [3:0]         last_be,
  output logic [LANES*4-1:0] wstrb
);

  logic [11:0] first_g;
  logic [11:0] end_g;
  logic [11:0] last_g;
  logic [11:0] g;

  assign first_g = 12'(off);
  assign end_g   = 12'(off) + 12'(n);
  assign last_g  = end_g - 12'd1;

  // Per-lane strobe selection; first_be wins for a single-DW request.
  always_comb begin
    wstrb = '0;
    g     = '0;
    for (int lane = 0; lane < LANES; lane++) begin
      g = 12'(beat) * 12'(LANES) + 12'(lane);
      if (g < first_g || g >= end_g)
        wstrb[lane*4 +: 4] = 4'h0;
      else if (g == first_g)
        wstrb[lane*4 +: 4] = first_be;
      else if (g == last_g && n > 11'd1)
        wstrb[lane*4 +: 4] = last_be;
      else
        wstrb[lane*4 +: 4] = 4'hF;
    end
  end

endmodule

// File: rtl/axi_master_wr_issuer.sv
// Rx-side AXI master write engine. Accepts one decoded inbound write,
// issues it as a single INCR burst on AW/W, waits for B and, for
// non-posted requests, hands a completion status to the completion
// generator. Only one transaction is in flight at a time.
module axi_master_wr_issuer
  import axi_master_wr_issuer_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ID_VALUE   = 0
) (
  input  logic                      axi_clk,
  input  logic                      ARESTn,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [9:0]                req_len,
  input  logic [3:0]                req_first_be,
  input  logic [3:0]                req_last_be,
  input  logic                      req_np,
  input  logic [9:0]                req_tag,
  input  logic [15:0]               req_requester_id,

  input  logic [AXI_DATA_WIDTH-1:0] wdata_in,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,

  axi_master_wr_issuer_if.master    axi,

  output logic                      cpl_valid,
  input  logic                      cpl_ready,
  output cpl_status_t               cpl_status,
  output logic [9:0]                cpl_tag,
  output logic [15:0]               cpl_requester_id
);

  localparam int LANES  = AXI_DATA_WIDTH / 32;
  localparam int BYTE_W = $clog2(AXI_DATA_WIDTH / 8);
  localparam int OFF_W  = $clog2(LANES);

  wr_state_t                  state;
  wr_desc_t                   desc;
  logic [OFF_W-1:0]           off;
  logic [7:0]                 beat_cnt;
  logic                       aw_valid;
  logic [AXI_ADDR_WIDTH-1:0]  aw_addr;
  logic [7:0]                 aw_len;
  logic                       b_ready;
  logic                       w_active;
  logic [AXI_DATA_WIDTH/8-1:0] strb;

  logic [OFF_W-1:0]           req_off;
  logic [10:0]                req_n;
  logic [10:0]                req_beats;
  logic                       addr_lsb_unused;

  // Request decode: starting DW lane, DW count and beats spanned, all
  // evaluated in 11 bits so a 1024-DW request at lane 7 still fits.
  assign req_off         = req_addr[BYTE_W-1:2];
  assign req_n           = (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
  assign req_beats       = (11'(req_off) + req_n + 11'(LANES - 1)) >> OFF_W;
  assign addr_lsb_unused = ^req_addr[1:0];

  assign w_active = (state == ST_W);

  axi_master_wr_issuer_wstrb_gen #(
    .LANES (LANES),
    .OFF_W (OFF_W)
  ) u_wstrb_gen (
    .beat     (beat_cnt),
    .off      (off),
    .n        (desc.n),
    .first_be (desc.first_be),
    .last_be  (desc.last_be),
    .wstrb    (strb)
  );

  assign axi.AWVALID = aw_valid;
  assign axi.AWADDR  = aw_addr;
  assign axi.AWLEN   = aw_len;
  assign axi.AWSIZE  = 3'(BYTE_W);
  assign axi.AWBURST = AXI_BURST_INCR;
  assign axi.AWID    = AXI_ID_WIDTH'(AXI_ID_VALUE);

  assign axi.WVALID  = w_active & wdata_valid;
  assign axi.WDATA   = wdata_in;
  assign axi.WSTRB   = w_active ? strb : '0;
  assign axi.WLAST   = w_active & (beat_cnt == aw_len);
  assign wdata_ready = w_active & axi.WREADY;

  assign axi.BREADY  = b_ready;

  assign cpl_tag          = desc.tag;
  assign cpl_requester_id = desc.requester_id;

  // Transaction FSM with registered handshake outputs; req_ready rises one
  // cycle after reset release and again on every return to IDLE.
  always_ff @(posedge axi_clk or negedge ARESTn) begin
    if (!ARESTn) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      aw_valid   <= 1'b0;
      aw_addr    <= '0;
      aw_len     <= '0;
      b_ready    <= 1'b0;
      beat_cnt   <= '0;
      desc       <= '0;
      off        <= '0;
      cpl_valid  <= 1'b0;
      cpl_status <= CPL_SC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            desc <= '{n:            req_n,
                      first_be:     req_first_be,
                      last_be:      req_last_be,
                      np:           req_np,
                      tag:          req_tag,
                      requester_id: req_requester_id};
            off       <= req_off;
            aw_addr   <= {req_addr[AXI_ADDR_WIDTH-1:BYTE_W], {BYTE_W{1'b0}}};
            aw_len    <= 8'(req_beats - 11'd1);
            beat_cnt  <= '0;
            req_ready <= 1'b0;
            aw_valid  <= 1'b1;
            state     <= ST_AW;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_AW: begin
          if (axi.AWREADY) begin
            aw_valid <= 1'b0;
            state    <= ST_W;
          end
        end
        ST_W: begin
          if (wdata_valid && axi.WREADY) begin
            if (beat_cnt == aw_len) begin
              b_ready <= 1'b1;
              state   <= ST_B;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        ST_B: begin
          if (axi.BVALID) begin
            b_ready <= 1'b0;
            if (desc.np) begin
              cpl_valid  <= 1'b1;
              cpl_status <= bresp_to_status(axi.BRESP);
              state      <= ST_CPL;
            end else begin
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        ST_CPL: begin
          if (cpl_ready) begin
            cpl_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_wr_issuer.sv
// Directed bench for axi_master_wr_issuer: single-beat, unaligned,
// maximum-length, non-posted completions, handshake stalls and a reset
// in the middle of a burst.
module tb_axi_master_wr_issuer;
  import axi_master_wr_issuer_pkg::*;

  localparam int DW = 256;
  localparam int AW = 64;
  localparam int IW = 4;

  logic          axi_clk = 1'b0;
  logic          ARESTn;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [9:0]    req_len;
  logic [3:0]    req_first_be;
  logic [3:0]    req_last_be;
  logic          req_np;
  logic [9:0]    req_tag;
  logic [15:0]   req_requester_id;
  logic [DW-1:0] wdata_in;
  logic          wdata_valid;
  logic          wdata_ready;
  logic          cpl_valid;
  logic          cpl_ready;
  cpl_status_t   cpl_status;
  logic [9:0]    cpl_tag;
  logic [15:0]   cpl_requester_id;

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0] strb_q[$];
  logic        wlast_q[$];
  logic [63:0] obs_awaddr;
  logic [7:0]  obs_awlen;

  axi_master_wr_issuer_if #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW)
  ) bus ();

  axi_master_wr_issuer #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW),
    .AXI_ID_VALUE   (0)
  ) dut (
    .axi_clk          (axi_clk),
    .ARESTn           (ARESTn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .req_first_be     (req_first_be),
    .req_last_be      (req_last_be),
    .req_np           (req_np),
    .req_tag          (req_tag),
    .req_requester_id (req_requester_id),
    .wdata_in         (wdata_in),
    .wdata_valid      (wdata_valid),
    .wdata_ready      (wdata_ready),
    .axi              (bus),
    .cpl_valid        (cpl_valid),
    .cpl_ready        (cpl_ready),
    .cpl_status       (cpl_status),
    .cpl_tag          (cpl_tag),
    .cpl_requester_id (cpl_requester_id)
  );

  // 100 MHz clock
  always #5 axi_clk = ~axi_clk;

  // Hard stop if the directed sequence ever wedges
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no end of test, expected end before 300 us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one full transaction starting at a negedge; stall>0 inserts AW,
  // wdata_valid and WREADY bubbles. Observed AW fields and per-beat
  // WSTRB/WLAST are left in obs_* and the queues for the caller to check.
  task automatic applyStimulus(input logic [63:0] addr, input logic [9:0] len,
                               input logic [3:0] fe, input logic [3:0] le,
                               input logic np, input logic [9:0] tag,
                               input logic [15:0] rid, input logic [1:0] bresp,
                               input cpl_status_t exp_status,
                               input int stall, input int cpl_hold);
    int   cyc;
    int   beat;
    logic wv;
    logic wr;
    logic done;

    req_addr = addr; req_len = len; req_first_be = fe; req_last_be = le;
    req_np = np; req_tag = tag; req_requester_id = rid; req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge axi_clk);
      cyc++;
    end
    checkOutput("req_ready_wait", 256'(req_ready), 256'(1));
    @(negedge axi_clk);
    req_valid = 1'b0;
    checkOutput("awvalid_after_accept", 256'(bus.AWVALID), 256'(1));
    checkOutput("req_ready_low_busy", 256'(req_ready), 256'(0));
    checkOutput("bready_low_in_aw", 256'(bus.BREADY), 256'(0));
    obs_awaddr = bus.AWADDR;
    obs_awlen  = bus.AWLEN;

    for (int i = 0; i < stall; i++) begin
      @(negedge axi_clk);
      checkOutput("awvalid_held", 256'(bus.AWVALID), 256'(1));
      checkOutput("awaddr_stable", 256'(bus.AWADDR), 256'(obs_awaddr));
      checkOutput("awlen_stable", 256'(bus.AWLEN), 256'(obs_awlen));
    end
    bus.AWREADY = 1'b1;
    @(negedge axi_clk);
    bus.AWREADY = 1'b0;
    checkOutput("awvalid_dropped", 256'(bus.AWVALID), 256'(0));

    strb_q.delete();
    wlast_q.delete();
    done = 1'b0;
    beat = 0;
    cyc  = 0;
    while (!done && cyc < 400) begin
      wv = (stall == 0) || ((cyc % 3) != 1);
      wr = (stall == 0) || ((cyc % 4) != 2);
      wdata_valid = wv;
      bus.WREADY  = wr;
      wdata_in    = {8{32'hA500_0000 + 32'(beat)}};
      #1;
      checkOutput("wvalid_follow", 256'(bus.WVALID), 256'(wv));
      checkOutput("wdata_ready_follow", 256'(wdata_ready), 256'(wr));
      if (wv && wr) begin
        checkOutput("wdata_pass", 256'(bus.WDATA), 256'(wdata_in));
        strb_q.push_back(bus.WSTRB);
        wlast_q.push_back(bus.WLAST);
        if (bus.WLAST) done = 1'b1;
        beat++;
      end
      @(negedge axi_clk);
      cyc++;
    end
    wdata_valid = 1'b0;
    bus.WREADY  = 1'b0;
    checkOutput("wlast_handshake_seen", 256'(done), 256'(1));
    checkOutput("bready_in_b", 256'(bus.BREADY), 256'(1));
    checkOutput("wvalid_low_in_b", 256'(bus.WVALID), 256'(0));

    repeat (2) begin
      @(negedge axi_clk);
      checkOutput("bready_held", 256'(bus.BREADY), 256'(1));
    end
    bus.BVALID = 1'b1;
    bus.BRESP  = bresp;
    @(negedge axi_clk);
    bus.BVALID = 1'b0;
    bus.BRESP  = 2'b00;
    checkOutput("bready_low_after_b", 256'(bus.BREADY), 256'(0));

    if (np) begin
      checkOutput("cpl_valid_latency", 256'(cpl_valid), 256'(1));
      checkOutput("cpl_status", 256'(cpl_status), 256'(exp_status));
      checkOutput("cpl_tag", 256'(cpl_tag), 256'(tag));
      checkOutput("cpl_requester_id", 256'(cpl_requester_id), 256'(rid));
      for (int i = 0; i < cpl_hold; i++) begin
        @(negedge axi_clk);
        checkOutput("cpl_valid_held", 256'(cpl_valid), 256'(1));
        checkOutput("cpl_status_held", 256'(cpl_status), 256'(exp_status));
        checkOutput("cpl_tag_held", 256'(cpl_tag), 256'(tag));
      end
      cpl_ready = 1'b1;
      @(negedge axi_clk);
      cpl_ready = 1'b0;
      checkOutput("cpl_valid_cleared", 256'(cpl_valid), 256'(0));
      checkOutput("req_ready_after_cpl", 256'(req_ready), 256'(1));
    end else begin
      checkOutput("no_cpl_posted", 256'(cpl_valid), 256'(0));
      checkOutput("req_ready_after_b", 256'(req_ready), 256'(1));
    end
  endtask

  initial begin
    int cyc;
    int n_full;
    int n_last;

    ARESTn = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_len = '0; req_first_be = '0;
    req_last_be = '0; req_np = 1'b0; req_tag = '0; req_requester_id = '0;
    wdata_in = '0; wdata_valid = 1'b0; cpl_ready = 1'b0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;

    repeat (2) @(negedge axi_clk);
    $display("[TB] reset values");
    checkOutput("rst_req_ready", 256'(req_ready), 256'(0));
    checkOutput("rst_awvalid", 256'(bus.AWVALID), 256'(0));
    checkOutput("rst_awaddr", 256'(bus.AWADDR), 256'(0));
    checkOutput("rst_awlen", 256'(bus.AWLEN), 256'(0));
    checkOutput("rst_awsize", 256'(bus.AWSIZE), 256'(5));
    checkOutput("rst_awburst", 256'(bus.AWBURST), 256'(1));
    checkOutput("rst_awid", 256'(bus.AWID), 256'(0));
    checkOutput("rst_wvalid", 256'(bus.WVALID), 256'(0));
    checkOutput("rst_wstrb", 256'(bus.WSTRB), 256'(0));
    checkOutput("rst_wlast", 256'(bus.WLAST), 256'(0));
    checkOutput("rst_bready", 256'(bus.BREADY), 256'(0));
    checkOutput("rst_wdata_ready", 256'(wdata_ready), 256'(0));
    checkOutput("rst_cpl_valid", 256'(cpl_valid), 256'(0));
    checkOutput("rst_cpl_status", 256'(cpl_status), 256'(0));
    ARESTn = 1'b1;
    @(negedge axi_clk);

    $display("[TB] single DW posted write");
    applyStimulus(64'h1000, 10'd1, 4'hF, 4'h0, 1'b0, 10'h0, 16'h0,
                  BRESP_OKAY, CPL_SC, 0, 0);
    checkOutput("t1_awaddr", 256'(obs_awaddr), 256'(64'h1000));
    checkOutput("t1_awlen", 256'(obs_awlen), 256'(0));
    checkOutput("t1_beats", 256'(strb_q.size()), 256'(1));
    checkOutput("t1_wstrb0", 256'(strb_q[0]), 256'(32'h0000_000F));
    checkOutput("t1_wlast0", 256'(wlast_q[0]), 256'(1));

    $display("[TB] unaligned 3 DW write crossing a beat");
    applyStimulus(64'h101C, 10'd3, 4'hE, 4'h3, 1'b0, 10'h1, 16'h0001,
                  BRESP_OKAY, CPL_SC, 0, 0);
    checkOutput("t2_awaddr", 256'(obs_awaddr), 256'(64'h1000));
    checkOutput("t2_awlen", 256'(obs_awlen), 256'(1));
    checkOutput("t2_beats", 256'(strb_q.size()), 256'(2));
    checkOutput("t2_wstrb0", 256'(strb_q[0]), 256'(32'hE000_0000));
    checkOutput("t2_wstrb1", 256'(strb_q[1]), 256'(32'h0000_003F));
    checkOutput("t2_wlast0", 256'(wlast_q[0]), 256'(0));
    checkOutput("t2_wlast1", 256'(wlast_q[1]), 256'(1));

    $display("[TB] len=0 encodes 1024 DW");
    applyStimulus(64'h2000, 10'd0, 4'hF, 4'hF, 1'b0, 10'h2, 16'h0002,
                  BRESP_EXOKAY, CPL_SC, 0, 0);
    checkOutput("t3_awaddr", 256'(obs_awaddr), 256'(64'h2000));
    checkOutput("t3_awlen", 256'(obs_awlen), 256'(127));
    checkOutput("t3_beats", 256'(strb_q.size()), 256'(128));
    n_full = 0;
    n_last = 0;
    for (int i = 0; i < strb_q.size(); i++) begin
      if (strb_q[i] == 32'hFFFF_FFFF) n_full++;
      if (wlast_q[i]) n_last++;
    end
    checkOutput("t3_full_beats", 256'(n_full), 256'(128));
    checkOutput("t3_wlast_count", 256'(n_last), 256'(1));
    checkOutput("t3_wlast_127", 256'(wlast_q[127]), 256'(1));

    $display("[TB] non-posted write, SLVERR, completion held");
    applyStimulus(64'h3000, 10'd1, 4'hF, 4'h0, 1'b1, 10'h02A, 16'hBEEF,
                  BRESP_SLVERR, CPL_CA, 0, 5);
    checkOutput("t4_awlen", 256'(obs_awlen), 256'(0));

    $display("[TB] non-posted write, DECERR, 2 DW mid-beat");
    applyStimulus(64'h3008, 10'd2, 4'h3, 4'hC, 1'b1, 10'h155, 16'h1234,
                  BRESP_DECERR, CPL_UR, 0, 1);
    checkOutput("t4b_awaddr", 256'(obs_awaddr), 256'(64'h3000));
    checkOutput("t4b_awlen", 256'(obs_awlen), 256'(0));
    checkOutput("t4b_wstrb0", 256'(strb_q[0]), 256'(32'h0000_C300));

    $display("[TB] non-posted write, EXOKAY");
    applyStimulus(64'h3100, 10'd1, 4'h1, 4'h0, 1'b1, 10'h3FF, 16'h00AA,
                  BRESP_EXOKAY, CPL_SC, 0, 0);
    checkOutput("t4c_wstrb0", 256'(strb_q[0]), 256'(32'h0000_0001));

    $display("[TB] stalled AW, W and wdata_valid");
    applyStimulus(64'h4004, 10'd16, 4'h8, 4'h7, 1'b0, 10'h5, 16'h0005,
                  BRESP_OKAY, CPL_SC, 3, 0);
    checkOutput("t5_awaddr", 256'(obs_awaddr), 256'(64'h4000));
    checkOutput("t5_awlen", 256'(obs_awlen), 256'(2));
    checkOutput("t5_beats", 256'(strb_q.size()), 256'(3));
    checkOutput("t5_wstrb0", 256'(strb_q[0]), 256'(32'hFFFF_FF80));
    checkOutput("t5_wstrb1", 256'(strb_q[1]), 256'(32'hFFFF_FFFF));
    checkOutput("t5_wstrb2", 256'(strb_q[2]), 256'(32'h0000_0007));
    checkOutput("t5_wlast2", 256'(wlast_q[2]), 256'(1));

    $display("[TB] reset during beat 3 of 8");
    req_addr = 64'h5000; req_len = 10'd64; req_first_be = 4'hF; req_last_be = 4'hF;
    req_np = 1'b0; req_tag = 10'h6; req_requester_id = 16'h0006; req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge axi_clk);
      cyc++;
    end
    checkOutput("t6_req_ready", 256'(req_ready), 256'(1));
    @(negedge axi_clk);
    req_valid = 1'b0;
    checkOutput("t6_awlen", 256'(bus.AWLEN), 256'(7));
    bus.AWREADY = 1'b1;
    @(negedge axi_clk);
    bus.AWREADY = 1'b0;
    wdata_valid = 1'b1;
    bus.WREADY  = 1'b1;
    repeat (3) @(negedge axi_clk);
    #1;
    checkOutput("t6_wvalid_beat3", 256'(bus.WVALID), 256'(1));
    checkOutput("t6_wlast_beat3", 256'(bus.WLAST), 256'(0));
    checkOutput("t6_wstrb_beat3", 256'(bus.WSTRB), 256'(32'hFFFF_FFFF));
    #1;
    ARESTn = 1'b0;
    #1;
    checkOutput("t6_rst_wvalid", 256'(bus.WVALID), 256'(0));
    checkOutput("t6_rst_wdata_ready", 256'(wdata_ready), 256'(0));
    checkOutput("t6_rst_awvalid", 256'(bus.AWVALID), 256'(0));
    checkOutput("t6_rst_bready", 256'(bus.BREADY), 256'(0));
    checkOutput("t6_rst_cpl_valid", 256'(cpl_valid), 256'(0));
    checkOutput("t6_rst_req_ready", 256'(req_ready), 256'(0));
    checkOutput("t6_rst_wlast", 256'(bus.WLAST), 256'(0));
    @(negedge axi_clk);
    wdata_valid = 1'b0;
    bus.WREADY  = 1'b0;
    ARESTn = 1'b1;

    $display("[TB] request after reset release");
    applyStimulus(64'h6010, 10'd2, 4'hF, 4'h1, 1'b0, 10'h7, 16'h0007,
                  BRESP_OKAY, CPL_SC, 0, 0);
    checkOutput("t6b_awaddr", 256'(obs_awaddr), 256'(64'h6000));
    checkOutput("t6b_awlen", 256'(obs_awlen), 256'(0));
    checkOutput("t6b_wstrb0", 256'(strb_q[0]), 256'(32'h001F_0000));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
